fixed_to_float_packer: RTL and testbench
========================================

// Module: fixed_to_float_packer
// PURPOSE
//  Converts a signed two's-complement fixed-point value (2 integer bits incl. sign,
//  WIDTH fractional bits) into an IEEE-754 single-precision word.
//  Output stage of the CORDIC datapath: CORDIC results leave the core as
//  floats for the host. Inverse of the float->fixed unpacker at the core input.
//  Registered, with one cycle of latency.
// PARAMETERS
//  WIDTH  24  fractional bits of in_fixed; legal range 1..60
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        in_fixed is valid this cycle
//  in_fixed   in   WIDTH+2  signed fixed-point; value = $signed(in_fixed) / 2**WIDTH, range [-2,2)
//  out_valid  out  1        out_float is valid this cycle
//  out_float  out  32       IEEE-754 single {sign, exp[7:0], frac[22:0]}
// BEHAVIOUR
//  - reset=1 at a rising edge: out_valid<=0 and out_float<=32'h0, overriding any in_valid.
//  - Latency is exactly 1 cycle. in_valid/in_fixed sampled at edge N give
//    out_valid/out_float at edge N. There is no backpressure, so a new input is
//    accepted every cycle.
//  - in_valid=0: out_valid<=0 and out_float holds its previous value.
//  - sign = in_fixed[WIDTH+1].
//  - mag = |in_fixed|, computed as a WIDTH+2-bit unsigned value.
//    The most negative input -2.0 (10_0..0) therefore has mag = 2**(WIDTH+1)
//    and is not saturated.
//  - mag==0: out_float = 32'h0000_0000. The result is always +0, never -0.
//  - Otherwise, let p = index of the leading '1' in mag (0..WIDTH+1):
//      exp  = 127 + p - WIDTH  (always in the normal range for legal WIDTH;
//             no denormals, inf or NaN are ever produced)
//      frac = the p bits below the leading one, left-aligned into 23 bits:
//             if p <= 23: frac = mag[p-1:0] << (23-p), zero-padded;
//             if p > 23: frac = mag[p-1:p-23], truncated (round toward zero).
//  - Leading-one detection and the normalising shift are combinational,
//    followed by the output register. No multi-cycle FSM.
//  - Pure function of the sampled input; no dependency on earlier samples.
//  - Round trip float->unpacker->packer is exact for any normal float in
//    [2**-WIDTH, 2) whose significand fits in WIDTH+1+exp bits.
// TESTING  (WIDTH=24; one input per cycle with in_valid=1, check one cycle later)
//  1. in_fixed=26'h100_0000 (+1.0) -> 32'h3F80_0000. in_fixed=26'h300_0000 (-1.0) -> 32'hBF80_0000.
//  2. in_fixed=26'h080_0000 (0.5) -> 32'h3F00_0000. in_fixed=26'h0C7_AE14 -> 32'h3F47_AE14.
//     in_fixed=26'h08A_9594 -> 32'h3F0A_9594.
//  3. Extremes:
//     in_fixed=26'h000_0001 (2**-24) -> 32'h3380_0000;
//     26'h200_0000 (-2.0) -> 32'hC000_0000;
//     26'h1FF_FFFF -> 32'h3FFF_FFFF (truncated);
//     26'h0 -> 32'h0000_0000.
//  4. Reset asserted for one cycle with in_valid=1 -> out_valid=0, out_float=0.
//     After release, the first valid input appears exactly one cycle later.
//  5. Back-to-back stream 1.0, -1.0, 0.5 on three consecutive cycles
//     -> 3F800000, BF800000, 3F000000 on consecutive cycles.
//     Then deassert in_valid -> out_valid=0 and out_float holds 3F000000.
//  6. Random sweep of 10k inputs vs. a reference model (exact normalise + truncate) -> bit-exact match.

Source files
------------

// File: rtl/fixed_to_float_packer.sv
// fixed_to_float_packer: signed fixed-point (2 int bits, WIDTH frac bits) to IEEE-754 single, 1-cycle latency
module fixed_to_float_packer #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH+1:0] in_fixed,
    output logic             out_valid,
    output logic [31:0]      out_float
);
    localparam int W2 = WIDTH + 2;
    logic          sign;
    logic [W2-1:0] mag;
    logic [6:0]    p;
    logic [6:0]    sh;
    logic [7:0]    expo;
    logic [22:0]   frac;
    logic [31:0]   result;
    always_comb begin
        sign = in_fixed[W2-1];
        mag = sign ? W2'(-in_fixed) : in_fixed;
        p = '0;
        for (int i = 0; i < W2; i++)
            if (mag[i]) p = 7'(i);
        sh = 7'(W2 - 1) - p;
        expo = 8'(int'(p) + 127 - WIDTH);
        // Align the leading one just above a 23-bit window; the window is the fraction.
        frac = 23'(({mag, 23'b0} << sh) >> (W2 - 1));
        result = (mag == '0) ? 32'h0 : {sign, expo, frac};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_float <= 32'h0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_float <= result;
        end
    end
endmodule

// File: tb/tb_fixed_to_float_packer.sv
// tb_fixed_to_float_packer: directed and randomized checks against an arithmetic reference model
module tb_fixed_to_float_packer;
    localparam int WIDTH = 24;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [WIDTH+1:0]  in_fixed = '0;
    logic              out_valid;
    logic [31:0]       out_float;
    int errors = 0;
    int checks = 0;
    logic [31:0] held;

    fixed_to_float_packer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_fixed(in_fixed),
        .out_valid(out_valid), .out_float(out_float)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // value = signed(x)/2^WIDTH; float = (-1)^s * 2^(p-WIDTH) * (mag/2^p), fraction truncated
    function automatic logic [31:0] model(input logic [WIDTH+1:0] x);
        longint v, m, rem;
        int p;
        logic [22:0] f;
        logic s;
        v = longint'($signed(x));
        s = v < 0;
        m = s ? -v : v;
        if (m == 0) return 32'h0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        rem = m - (longint'(1) << p);
        f = (p <= 23) ? 23'(rem << (23 - p)) : 23'(rem >> (p - 23));
        return {s, 8'(127 + p - WIDTH), f};
    endfunction

    task automatic step(input logic v, input logic [WIDTH+1:0] x);
        @(negedge clk);
        in_valid = v;
        in_fixed = x;
        @(posedge clk);
        #1;
    endtask

    task automatic vcheck(input string tag, input logic [WIDTH+1:0] x, input logic [31:0] exp);
        step(1'b1, x);
        check({tag, "_v"}, {31'b0, out_valid}, 32'h1);
        check(tag, out_float, exp);
    endtask

    initial begin
        in_valid = 1'b1;
        in_fixed = 26'h100_0000;
        @(posedge clk);
        #1;
        check("rst_v", {31'b0, out_valid}, 32'h0);
        check("rst_f", out_float, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        vcheck("p1", 26'h100_0000, 32'h3F80_0000);
        vcheck("m1", 26'h300_0000, 32'hBF80_0000);
        vcheck("half", 26'h080_0000, 32'h3F00_0000);
        vcheck("c7", 26'h0C7_AE14, 32'h3F47_AE14);
        vcheck("8a", 26'h08A_9594, 32'h3F0A_9594);
        vcheck("tiny", 26'h000_0001, 32'h3380_0000);
        vcheck("m2", 26'h200_0000, 32'hC000_0000);
        vcheck("max", 26'h1FF_FFFF, 32'h3FFF_FFFF);
        vcheck("mlsb", 26'h3FF_FFFF, 32'hB380_0000);
        vcheck("zero", 26'h000_0000, 32'h0000_0000);
        vcheck("s1", 26'h100_0000, 32'h3F80_0000);
        vcheck("s2", 26'h300_0000, 32'hBF80_0000);
        vcheck("s3", 26'h080_0000, 32'h3F00_0000);
        step(1'b0, 26'h100_0000);
        check("idle_v", {31'b0, out_valid}, 32'h0);
        check("idle_hold", out_float, 32'h3F00_0000);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b1;
        in_fixed = 26'h300_0000;
        @(posedge clk);
        #1;
        check("rst2_v", {31'b0, out_valid}, 32'h0);
        check("rst2_f", out_float, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        in_fixed = 26'h080_0000;
        @(posedge clk);
        #1;
        check("post_v", {31'b0, out_valid}, 32'h1);
        check("post_f", out_float, 32'h3F00_0000);
        held = out_float;
        for (int i = 0; i < 10000; i++) begin
            logic [WIDTH+1:0] x;
            logic v;
            x = 26'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) x = -x;
            v = $urandom_range(0, 7) != 0;
            step(v, x);
            if (v) held = model(x);
            check("rnd_v", {31'b0, out_valid}, {31'b0, v});
            check("rnd_f", out_float, held);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
